mux_n_1_pipe: RTL and testbench

- Parametrised, registered N-to-1 multiplexer for the ALU datapath.
- Generalises the 2:1 gate-level mux to N channels of WIDTH bits.
- Adds per-channel valid/ready handshakes, one output register stage, and two selection modes: explicit select or round-robin.
- Sits between operand sources (register file, immediate, forwarding paths) and ALU operand inputs.

---
 rtl/mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/mux_n_1_pipe.sv | 90 +++++++++
 tb/tb_mux_n_1_pipe.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared modes and defaults for the N-to-1 pipelined operand mux
package mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_N     = 4;
    localparam int STALL_CNT_W   = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from ptr+1 with modulo-N wrap
module rr_arbiter #(
    parameter int N = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    // first requester after ptr wins; wrap done by subtraction so N need not be a power of two
    always_comb begin
        int c;
        c         = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            if (!gnt_valid && req[c]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(c);
            end
        end
    end

endmodule

// File: rtl/mux_n_1_pipe.sv
// mux_n_1_pipe: registered N-to-1 mux with valid/ready handshakes, explicit-select or round-robin
// Optional: define MUX_STALL_CNT_EN to add a saturating backpressure cycle counter (stall_cnt).
module mux_n_1_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    localparam int NP = 1 << SEL_W;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NP-1:0]    valid_pad;
    logic             arb_valid, gnt_valid, can_load, fire;
    logic [SEL_W-1:0] arb_idx, gnt_idx;

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    // grant selection and next-state; padding in_valid makes sel >= N read as not valid
    always_comb begin
        valid_pad   = NP'(in_valid);
        gnt_valid   = (mode == MODE_RR) ? arb_valid : valid_pad[sel];
        gnt_idx     = (mode == MODE_RR) ? arb_idx : sel;
        can_load    = !out_valid_q || out_ready;
        fire        = can_load && gnt_valid;
        in_ready    = fire ? (N'(1) << gnt_idx) : '0;
        out_data_d  = fire ? in_data[gnt_idx*WIDTH +: WIDTH] : out_data_q;
        out_sel_d   = fire ? gnt_idx : out_sel_q;
        out_valid_d = fire || (out_valid_q && !out_ready);
        rr_ptr_d    = (fire && mode == MODE_RR) ? gnt_idx : rr_ptr_q;
    end

    // output register and round-robin pointer; pointer starts at N-1 so channel 0 goes first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SEL_W'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

`ifdef MUX_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // saturating count of cycles where a registered word is held by backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else if (out_valid_q && !out_ready && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// tb_mux_n_1_pipe: table-driven and directed checks of mux_n_1_pipe (N=4 and N=3 instances)
module tb_mux_n_1_pipe;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'hDEAD_BEEF;
    localparam logic [31:0] D3 = 32'h4444_0003;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         mode = 1'b0;
    logic [1:0]   sel = '0;
    logic [127:0] in_data = {D3, D2, D1, D0};
    logic [3:0]   in_valid = '0;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_valid;
    logic         out_ready = 1'b0;

    logic         mode3 = 1'b0;
    logic [1:0]   sel3 = '0;
    logic [23:0]  in_data3 = {8'hA2, 8'hA1, 8'hA0};
    logic [2:0]   in_valid3 = '0;
    logic [2:0]   in_ready3;
    logic [7:0]   out_data3;
    logic [1:0]   out_sel3;
    logic         out_valid3;
    logic         out_ready3 = 1'b1;

`ifdef MUX_STALL_CNT_EN
    logic [15:0] stall_cnt, stall_cnt3;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mux_n_1_pipe #(.WIDTH(32), .N(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    mux_n_1_pipe #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef MUX_STALL_CNT_EN
        , .stall_cnt(stall_cnt3)
`endif
    );

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic        rdy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_data;
        logic [1:0]  exp_sel;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // mode, sel, valid, rdy, exp in_ready, exp out_valid, exp data, exp sel
        vecs[0] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, D0, 2'd0};
        vecs[1] = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, D2, 2'd2};
        vecs[2] = '{1'b0, 2'd2, 4'b0001, 1'b1, 4'b0000, 1'b0, D2, 2'd2};
        vecs[3] = '{1'b1, 2'd0, 4'b0110, 1'b0, 4'b0010, 1'b1, D1, 2'd1};
        vecs[4] = '{1'b1, 2'd0, 4'b0110, 1'b0, 4'b0000, 1'b1, D1, 2'd1};
        vecs[5] = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0100, 1'b1, D2, 2'd2};
        vecs[6] = '{1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, D0, 2'd0};
        vecs[7] = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, D3, 2'd3};
        vecs[8] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, D1, 2'd1};
        vecs[9] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, D1, 2'd1};

        #3;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_sel", out_sel, 0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            mode = vecs[i].mode;
            sel = vecs[i].sel;
            in_valid = vecs[i].valid;
            out_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].exp_rdy);
            tick();
            chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].exp_ov);
            if (vecs[i].exp_ov) begin
                chk($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
                chk($sformatf("vec%0d out_sel", i), out_sel, vecs[i].exp_sel);
            end
        end

        mode = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        tick();
        chk("pre-reset out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst out_data", out_data, 0);
        chk("async rst out_sel", out_sel, 0);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("rr fair %0d sel", k), out_sel, k % 4);
            chk($sformatf("rr fair %0d valid", k), out_valid, 1);
        end

        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall %0d in_ready", k), in_ready, 0);
            tick();
            chk($sformatf("stall %0d out_sel", k), out_sel, 3);
            chk($sformatf("stall %0d out_data", k), out_data, D3);
        end
`ifdef MUX_STALL_CNT_EN
        chk("stall_cnt after 5", stall_cnt, 5);
`endif
        out_ready = 1'b1;
        #1;
        chk("drain in_ready", in_ready, 4'b0001);
        tick();
        chk("reload out_sel", out_sel, 0);
        chk("reload out_data", out_data, D0);
        chk("reload out_valid", out_valid, 1);
`ifdef MUX_STALL_CNT_EN
        chk("stall_cnt hold", stall_cnt, 5);
`endif

        mode3 = 1'b0;
        sel3 = 2'd3;
        in_valid3 = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("n3 sel3 in_ready %0d", k), in_ready3, 0);
            tick();
            chk($sformatf("n3 sel3 out_valid %0d", k), out_valid3, 0);
        end
        mode3 = 1'b1;
        in_valid3 = 3'b101;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("n3 rr sel %0d", k), out_sel3, (k % 2) * 2);
            chk($sformatf("n3 rr data %0d", k), out_data3, (k % 2) ? 8'hA2 : 8'hA0);
        end

`ifdef MUX_STALL_CNT_EN
        out_ready = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("stall_cnt saturated", stall_cnt, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_cnt stays saturated", stall_cnt, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
